// File: rtl/sequencer_control.sv
// MC14500B instruction sequencer: steps the PC over a req/ack handshake, fetches
// instruction words, runs control-flow opcodes locally and hands the rest to the logic unit.
module sequencer_control #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  output logic                  pc_req,
  input  logic                  pc_ack,
  output logic                  pc_reset,
  output logic                  pc_write,
  output logic [ADDR_WIDTH-1:0] pc_load_addr,
  input  logic [ADDR_WIDTH-1:0] pc_addr,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [ADDR_WIDTH+3:0] mem_rdata,
  input  logic                  rr,
  output logic                  exec_valid,
  output logic [3:0]            exec_op,
  output logic [ADDR_WIDTH-1:0] exec_operand,
  input  logic                  exec_ready,
  output logic                  flag0,
  output logic                  flagf,
  output logic                  stack_err
);

  localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [2:0] {
    BOOT, BOOT_REL, STEP_REQ, STEP_REL, FETCH, DECODE, EXEC
  } state_t;

  state_t state, n_state;

  logic                  skip, n_skip;
  logic [SP_W-1:0]       sp;
  logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];
  logic [IDX_W-1:0]      push_idx, pop_idx;
  logic                  push, pop;

  logic                  n_req, n_reset, n_write, n_mem_rd, n_exec_valid;
  logic                  n_flag0, n_flagf, n_err;
  logic [ADDR_WIDTH-1:0] n_load, n_operand;
  logic [3:0]            n_op;

  logic                  step_go, step_load;
  logic [ADDR_WIDTH-1:0] step_target;

  logic [3:0]            opcode;
  logic [ADDR_WIDTH-1:0] operand;

  assign opcode   = mem_rdata[ADDR_WIDTH+3:ADDR_WIDTH];
  assign operand  = mem_rdata[ADDR_WIDTH-1:0];
  assign mem_addr = pc_addr;
  assign push_idx = IDX_W'(sp);
  assign pop_idx  = IDX_W'(sp - SP_W'(1));

  always_comb begin
    n_state      = state;
    n_req        = pc_req;
    n_reset      = pc_reset;
    n_write      = pc_write;
    n_load       = pc_load_addr;
    n_mem_rd     = 1'b0;
    n_exec_valid = exec_valid;
    n_op         = exec_op;
    n_operand    = exec_operand;
    n_flag0      = 1'b0;
    n_flagf      = 1'b0;
    n_err        = stack_err;
    n_skip       = skip;
    push         = 1'b0;
    pop          = 1'b0;
    step_go      = 1'b0;
    step_load    = 1'b0;
    step_target  = '0;

    unique case (state)
      BOOT: begin
        if (!pc_req) begin
          n_req   = 1'b1;
          n_reset = 1'b1;
        end else if (pc_ack) begin
          n_req   = 1'b0;
          n_state = BOOT_REL;
        end
      end
      BOOT_REL: begin
        if (!pc_ack) begin
          n_reset = 1'b0;
          step_go = 1'b1;
        end
      end
      STEP_REQ: begin
        if (pc_req) begin
          if (pc_ack) begin
            n_req   = 1'b0;
            n_state = STEP_REL;
          end
        end else if (run) begin
          n_req = 1'b1;
        end
      end
      STEP_REL: begin
        if (!pc_ack) begin
          n_write  = 1'b0;
          n_reset  = 1'b0;
          n_load   = '0;
          n_mem_rd = 1'b1;
          n_state  = FETCH;
        end
      end
      FETCH: n_state = DECODE;
      DECODE: begin
        if (skip) begin
          n_skip  = 1'b0;
          step_go = 1'b1;
        end else begin
          unique case (opcode)
            4'h0: begin
              n_flag0 = 1'b1;
              step_go = 1'b1;
            end
            4'hF: begin
              n_flagf = 1'b1;
              step_go = 1'b1;
            end
            4'hC: begin
              if (sp == SP_W'(STACK_DEPTH)) n_err = 1'b1;
              else                          push  = 1'b1;
              step_go     = 1'b1;
              step_load   = 1'b1;
              step_target = operand;
            end
            4'hD: begin
              step_go = 1'b1;
              if (sp == '0) begin
                n_err = 1'b1;
              end else begin
                // Return lands on the JMP itself; skip makes the refetch a no-op.
                pop         = 1'b1;
                n_skip      = 1'b1;
                step_load   = 1'b1;
                step_target = stack_mem[pop_idx];
              end
            end
            4'hE: begin
              if (!rr) n_skip = 1'b1;
              step_go = 1'b1;
            end
            default: begin
              n_exec_valid = 1'b1;
              n_op         = opcode;
              n_operand    = operand;
              n_state      = EXEC;
            end
          endcase
        end
      end
      EXEC: begin
        if (exec_ready) begin
          n_exec_valid = 1'b0;
          step_go      = 1'b1;
        end
      end
      default: n_state = BOOT;
    endcase

    // Request is raised on STEP_REQ entry so a combinational ack completes in one cycle.
    if (step_go) begin
      n_state = STEP_REQ;
      n_req   = run;
      n_write = step_load;
      n_load  = step_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= BOOT;
      pc_req       <= 1'b0;
      pc_reset     <= 1'b0;
      pc_write     <= 1'b0;
      pc_load_addr <= '0;
      mem_rd       <= 1'b0;
      exec_valid   <= 1'b0;
      exec_op      <= '0;
      exec_operand <= '0;
      flag0        <= 1'b0;
      flagf        <= 1'b0;
      stack_err    <= 1'b0;
      skip         <= 1'b0;
      sp           <= '0;
    end else begin
      state        <= n_state;
      pc_req       <= n_req;
      pc_reset     <= n_reset;
      pc_write     <= n_write;
      pc_load_addr <= n_load;
      mem_rd       <= n_mem_rd;
      exec_valid   <= n_exec_valid;
      exec_op      <= n_op;
      exec_operand <= n_operand;
      flag0        <= n_flag0;
      flagf        <= n_flagf;
      stack_err    <= n_err;
      skip         <= n_skip;
      if (push)     sp <= sp + SP_W'(1);
      else if (pop) sp <= sp - SP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) stack_mem[push_idx] <= pc_addr;
  end

endmodule

// File: tb/tb_sequencer_control.sv
// Directed bench for sequencer_control with a behavioural PC and program memory;
// fetch addresses and logic-unit operations are checked through expectation queues.
module tb_sequencer_control;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        pc_req, pc_ack, pc_reset, pc_write;
  logic [7:0]  pc_load_addr, pc_addr, mem_addr, exec_operand;
  logic        mem_rd, rr = 1'b0, exec_valid, exec_ready = 1'b1;
  logic [11:0] mem_rdata = '0;
  logic [3:0]  exec_op;
  logic        flag0, flagf, stack_err;

  logic        ack_hold = 1'b0;
  logic        mon_en = 1'b0;
  logic [7:0]  pc = 8'h00;
  logic        req_d = 1'b0;
  logic        ev_d = 1'b0;
  logic [11:0] mem [256];

  logic [7:0]  fetch_q [$];
  logic [11:0] exec_q  [$];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sequencer_control #(.ADDR_WIDTH(8), .STACK_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .run(run),
    .pc_req(pc_req), .pc_ack(pc_ack), .pc_reset(pc_reset), .pc_write(pc_write),
    .pc_load_addr(pc_load_addr), .pc_addr(pc_addr),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .rr(rr), .exec_valid(exec_valid), .exec_op(exec_op), .exec_operand(exec_operand),
    .exec_ready(exec_ready), .flag0(flag0), .flagf(flagf), .stack_err(stack_err)
  );

  // Program counter: acts on the rising edge of req; ack mirrors req unless held.
  assign pc_ack  = pc_req & ~ack_hold;
  assign pc_addr = pc;
  always @(posedge clk) begin
    req_d <= pc_req;
    if (pc_req && !req_d) begin
      if (pc_reset)      pc <= 8'hFF;
      else if (pc_write) pc <= pc_load_addr;
      else               pc <= pc + 8'd1;
    end
  end

  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && mem_rd && fetch_q.size() != 0) chk("fetch_addr", 32'(mem_addr), 32'(fetch_q.pop_front()));
    if (mon_en && exec_valid && !ev_d) begin
      chk("exec_expected", 32'(exec_q.size() != 0), 32'd1);
      if (exec_q.size() != 0) chk("exec_word", 32'({exec_op, exec_operand}), 32'(exec_q.pop_front()));
    end
    ev_d <= exec_valid;
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 12'h000;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    reset  = 1'b1;
    fetch_q.delete();
    exec_q.delete();
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic push_fetch_range(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) fetch_q.push_back(8'(a));
  endtask

  task automatic wait_fetches(input string tag, input int max_cyc);
    for (int i = 0; i < max_cyc && fetch_q.size() != 0; i++) @(negedge clk);
    chk(tag, 32'(fetch_q.size()), 32'd0);
    repeat (8) @(negedge clk);
    chk({tag, "_exec_left"}, 32'(exec_q.size()), 32'd0);
  endtask

  task automatic wait_req(input string tag, input int max_cyc);
    int i;
    @(negedge clk);
    for (i = 0; i < max_cyc && !pc_req; i++) @(negedge clk);
    chk(tag, 32'(pc_req), 32'd1);
  endtask

  task automatic wait_pc(input string tag, input logic [7:0] a, input int max_cyc);
    int i;
    for (i = 0; i < max_cyc && pc_addr !== a; i++) @(negedge clk);
    chk(tag, 32'(pc_addr), 32'(a));
  endtask

  task automatic wait_flag0(input string tag, input int max_cyc);
    int i;
    for (i = 0; i < max_cyc && !flag0; i++) @(negedge clk);
    chk(tag, 32'(flag0), 32'd1);
  endtask

  initial begin
    int gap;
    clear_mem();

    // Reset state while reset is held
    repeat (3) @(negedge clk);
    chk("rst_pc_req", 32'(pc_req), 32'd0);
    chk("rst_pc_reset", 32'(pc_reset), 32'd0);
    chk("rst_pc_write", 32'(pc_write), 32'd0);
    chk("rst_mem_rd", 32'(mem_rd), 32'd0);
    chk("rst_exec_valid", 32'(exec_valid), 32'd0);
    chk("rst_flags", 32'({flag0, flagf, stack_err}), 32'd0);
    chk("rst_load_addr", 32'(pc_load_addr), 32'd0);
    chk("rst_exec_word", 32'({exec_op, exec_operand}), 32'd0);

    // All-NOPO program; boot proceeds with run low, then idles
    do_reset();
    wait_req("boot_req", 20);
    chk("boot_pc_reset", 32'(pc_reset), 32'd1);
    @(negedge clk);
    chk("boot_pc_ff", 32'(pc_addr), 32'hFF);
    repeat (8) @(negedge clk);
    chk("idle_no_req", 32'({pc_req, mem_rd}), 32'd0);
    push_fetch_range(0, 7);
    run = 1'b1;
    wait_fetches("nopo_fetch", 100);
    wait_flag0("flag0_first", 20);
    gap = 0;
    @(negedge clk);
    for (int i = 0; i < 20 && !flag0; i++) begin gap++; @(negedge clk); end
    chk("flag0_period", 32'(gap + 1), 32'd4);

    // JMP 0x40 at 0x10, RTN at 0x40, LD 0x55 at 0x11
    run = 1'b0;
    clear_mem();
    mem[8'h10] = 12'hC40;
    mem[8'h40] = 12'hD00;
    mem[8'h11] = 12'h155;
    do_reset();
    push_fetch_range(0, 16);
    fetch_q.push_back(8'h40);
    fetch_q.push_back(8'h10);
    fetch_q.push_back(8'h11);
    fetch_q.push_back(8'h12);
    fetch_q.push_back(8'h13);
    exec_q.push_back(12'h155);
    run = 1'b1;
    wait_fetches("jmp_rtn_fetch", 300);
    chk("jmp_rtn_no_err", 32'(stack_err), 32'd0);

    // SKZ with rr=0 discards the following LD
    run = 1'b0;
    clear_mem();
    mem[5] = 12'hE00;
    mem[6] = 12'h155;
    rr = 1'b0;
    do_reset();
    push_fetch_range(0, 8);
    run = 1'b1;
    wait_fetches("skz_rr0", 150);

    // SKZ with rr=1 lets the LD execute
    run = 1'b0;
    rr  = 1'b1;
    do_reset();
    push_fetch_range(0, 8);
    exec_q.push_back(12'h155);
    run = 1'b1;
    wait_fetches("skz_rr1", 150);

    // Five nested JMPs against a four-deep stack, then five RTNs
    run = 1'b0;
    rr  = 1'b0;
    clear_mem();
    mem[8'h00] = 12'hC20;
    mem[8'h20] = 12'hC30;
    mem[8'h30] = 12'hC40;
    mem[8'h40] = 12'hC50;
    mem[8'h50] = 12'hC60;
    mem[8'h60] = 12'hD00;
    mem[8'h41] = 12'hD00;
    mem[8'h31] = 12'hD00;
    mem[8'h21] = 12'hD00;
    mem[8'h01] = 12'hD00;
    do_reset();
    begin
      logic [7:0] seq [16] = '{8'h00, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h40, 8'h41,
                              8'h30, 8'h31, 8'h20, 8'h21, 8'h00, 8'h01, 8'h02, 8'h03};
      for (int i = 0; i < 16; i++) fetch_q.push_back(seq[i]);
    end
    run = 1'b1;
    wait_pc("nest_reach_50", 8'h50, 200);
    chk("nest_err_before", 32'(stack_err), 32'd0);
    wait_pc("nest_reach_60", 8'h60, 50);
    chk("nest_err_overflow", 32'(stack_err), 32'd1);
    wait_fetches("nest_fetch", 300);
    chk("nest_err_sticky", 32'(stack_err), 32'd1);

    // AND held off by exec_ready for 10 cycles
    run = 1'b0;
    clear_mem();
    mem[3] = 12'h3A5;
    exec_ready = 1'b0;
    do_reset();
    push_fetch_range(0, 5);
    exec_q.push_back(12'h3A5);
    run = 1'b1;
    for (int i = 0; i < 100 && !exec_valid; i++) @(negedge clk);
    chk("hold_exec_valid", 32'(exec_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(exec_valid), 32'd1);
      chk("hold_word", 32'({exec_op, exec_operand}), 32'h3A5);
      chk("hold_no_step", 32'({pc_req, pc_addr}), 32'h003);
    end
    exec_ready = 1'b1;
    @(negedge clk);
    chk("hold_release", 32'(exec_valid), 32'd0);
    wait_fetches("hold_fetch", 100);

    // Reset during a stalled step request
    run = 1'b0;
    clear_mem();
    do_reset();
    run = 1'b1;
    for (int i = 0; i < 50 && !mem_rd; i++) @(negedge clk);
    chk("midrst_first_fetch", 32'(mem_rd), 32'd1);
    ack_hold = 1'b1;
    wait_req("midrst_req", 20);
    repeat (2) @(negedge clk);
    chk("midrst_req_held", 32'(pc_req), 32'd1);
    reset  = 1'b1;
    mon_en = 1'b0;
    @(negedge clk);
    chk("midrst_req_drop", 32'(pc_req), 32'd0);
    ack_hold = 1'b0;
    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;
    push_fetch_range(0, 2);
    wait_req("midrst_boot_req", 20);
    chk("midrst_boot_reset", 32'(pc_reset), 32'd1);
    wait_fetches("midrst_fetch", 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
